// File: rtl/bsn_pkg.sv
// Shared helpers for the bitonic sorting network: log2, stage count and the
// per-stage (k, j) schedule used to wire compare-exchange lanes.
package bsn_pkg;

  localparam int BSN_MAX_INPUTS = 64;

  function automatic int bsn_clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  function automatic int bsn_stages(input int n);
    int l;
    l = bsn_clog2(n);
    return (l * (l + 1)) / 2;
  endfunction

  // log2 of block size k for pipeline stage s (k = 2..N, j = k/2..1 order)
  function automatic int bsn_stage_klog(input int log_n, input int s);
    int c, res;
    c = 0;
    res = 0;
    for (int p = 1; p <= log_n; p++)
      for (int q = p - 1; q >= 0; q--) begin
        if (c == s) res = p;
        c++;
      end
    return res;
  endfunction

  // log2 of stride j for pipeline stage s
  function automatic int bsn_stage_jlog(input int log_n, input int s);
    int c, res;
    c = 0;
    res = 0;
    for (int p = 1; p <= log_n; p++)
      for (int q = p - 1; q >= 0; q--) begin
        if (c == s) res = q;
        c++;
      end
    return res;
  endfunction

  // Lower lane of the p-th compare pair for stride 2**j_log
  function automatic int bsn_pair_lo(input int p, input int j_log);
    return ((p >> j_log) << (j_log + 1)) | (p & ((1 << j_log) - 1));
  endfunction

endpackage

// File: rtl/bsn_cmp_swap.sv
// Combinational compare-exchange of two {key, idx} pairs; up=1 places the
// smaller pair on the lo side.
module bsn_cmp_swap #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 3,
  parameter int SIGNED = 0
) (
  input  logic              up,
  input  logic [DATA_W-1:0] key_a,
  input  logic [IDX_W-1:0]  idx_a,
  input  logic [DATA_W-1:0] key_b,
  input  logic [IDX_W-1:0]  idx_b,
  output logic [DATA_W-1:0] key_lo,
  output logic [IDX_W-1:0]  idx_lo,
  output logic [DATA_W-1:0] key_hi,
  output logic [IDX_W-1:0]  idx_hi
);

  logic signed [DATA_W-1:0] skey_a;
  logic signed [DATA_W-1:0] skey_b;
  logic key_gt;
  logic a_gt_b;
  logic swap;

  assign skey_a = key_a;
  assign skey_b = key_b;
  assign key_gt = (SIGNED != 0) ? (skey_a > skey_b) : (key_a > key_b);
  // Index breaks ties so the composite compare key is always unique
  assign a_gt_b = key_gt || ((key_a == key_b) && (idx_a > idx_b));
  assign swap   = up ? a_gt_b : !a_gt_b;

  assign key_lo = swap ? key_b : key_a;
  assign idx_lo = swap ? idx_b : idx_a;
  assign key_hi = swap ? key_a : key_b;
  assign idx_hi = swap ? idx_a : idx_b;

endmodule

// File: rtl/bsn_pipe_sorter.sv
// Fully pipelined bitonic sorter: one transaction per cycle, one register per
// network stage, global stall on enable or output backpressure.
module bsn_pipe_sorter
  import bsn_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int N_INPUTS   = 8,
  parameter int SIGNED     = 0,
  parameter int IDX_W      = $clog2(N_INPUTS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           direction,
  input  logic [N_INPUTS*DATA_WIDTH-1:0] data_in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [N_INPUTS*DATA_WIDTH-1:0] data_out,
  output logic [N_INPUTS*IDX_W-1:0]      index_out,
  output logic                           out_dir
);

  localparam int LOG_N  = bsn_clog2(N_INPUTS);
  localparam int STAGES = bsn_stages(N_INPUTS);

  // Index 0 is the unregistered input; index s+1 is the register after stage s
  logic [DATA_WIDTH-1:0] key_p [STAGES+1][N_INPUTS];
  logic [IDX_W-1:0]      idx_p [STAGES+1][N_INPUTS];
  logic                  vld_p [STAGES+1];
  logic                  dir_p [STAGES+1];
  logic                  stall;

  assign stall    = !en || (vld_p[STAGES] && !out_ready);
  assign in_ready = !stall;
  assign vld_p[0] = in_valid;
  assign dir_p[0] = direction;

  for (genvar l = 0; l < N_INPUTS; l++) begin : g_lane
    assign key_p[0][l] = data_in[l*DATA_WIDTH +: DATA_WIDTH];
    assign idx_p[0][l] = IDX_W'(l);
    assign data_out[l*DATA_WIDTH +: DATA_WIDTH] = key_p[STAGES][l];
    assign index_out[l*IDX_W +: IDX_W]          = idx_p[STAGES][l];
  end

  assign out_valid = vld_p[STAGES];
  assign out_dir   = dir_p[STAGES];

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int K_LOG = bsn_stage_klog(LOG_N, s);
    localparam int J_LOG = bsn_stage_jlog(LOG_N, s);

    logic [DATA_WIDTH-1:0] nx_key [N_INPUTS];
    logic [IDX_W-1:0]      nx_idx [N_INPUTS];
    logic [DATA_WIDTH-1:0] key_q  [N_INPUTS];
    logic [IDX_W-1:0]      idx_q  [N_INPUTS];
    logic                  vld_q;
    logic                  dir_q;

    for (genvar p = 0; p < N_INPUTS/2; p++) begin : g_pair
      localparam int LO     = bsn_pair_lo(p, J_LOG);
      localparam int HI     = LO + (1 << J_LOG);
      localparam bit BLK_UP = ((LO >> K_LOG) & 1) == 0;
      logic up;

      assign up = BLK_UP ^ dir_p[s];

      bsn_cmp_swap #(
        .DATA_W (DATA_WIDTH),
        .IDX_W  (IDX_W),
        .SIGNED (SIGNED)
      ) u_cs (
        .up     (up),
        .key_a  (key_p[s][LO]),
        .idx_a  (idx_p[s][LO]),
        .key_b  (key_p[s][HI]),
        .idx_b  (idx_p[s][HI]),
        .key_lo (nx_key[LO]),
        .idx_lo (nx_idx[LO]),
        .key_hi (nx_key[HI]),
        .idx_hi (nx_idx[HI])
      );
    end

    // ---- stage s register boundary ----
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q <= 1'b0;
        dir_q <= 1'b0;
      end else if (!stall) begin
        vld_q <= vld_p[s];
        if (vld_p[s]) dir_q <= dir_p[s];
      end
    end

    if (s == STAGES - 1) begin : g_out
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          key_q <= '{default: '0};
          idx_q <= '{default: '0};
        end else if (!stall && vld_p[s]) begin
          key_q <= nx_key;
          idx_q <= nx_idx;
        end
      end
    end else begin : g_mid
      // Bubbles leave the data registers untouched
      always_ff @(posedge clk) begin
        if (!stall && vld_p[s]) begin
          key_q <= nx_key;
          idx_q <= nx_idx;
        end
      end
    end

    assign vld_p[s+1] = vld_q;
    assign dir_p[s+1] = dir_q;
    for (genvar l = 0; l < N_INPUTS; l++) begin : g_fwd
      assign key_p[s+1][l] = key_q[l];
      assign idx_p[s+1][l] = idx_q[l];
    end
  end

endmodule
